// File: rtl/cfi_pkg.sv
// Shared types for the CFI commit-path logging blocks.
package cfi_pkg;

  typedef struct packed {
    logic [31:0] addr_pc;
    logic [31:0] target;
    logic [1:0]  kind;
  } cfi_log_t;

  // Widest push vector the popcount helper handles.
  localparam int unsigned MAX_PORTS = 8;

  function automatic logic [3:0] cfi_popcount(input logic [MAX_PORTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cfi_log_compact.sv
// Per-port push decode: each pushing port's slot offset is the number of
// pushing ports below it, so records pack densely in ascending port order.
module cfi_log_compact
  import cfi_pkg::*;
#(
  parameter int unsigned NR    = 2,
  parameter int unsigned OFF_W = $clog2(NR + 1)
) (
  input  logic [NR-1:0]            cfi,
  input  logic [NR-1:0]            commit_ack,
  output logic [NR-1:0]            push,
  output logic [NR-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]         n_push
);

  if (NR > MAX_PORTS) begin : g_port_check
    $error("cfi_log_compact: NR exceeds MAX_PORTS");
  end

  assign push   = cfi & commit_ack;
  assign n_push = OFF_W'(cfi_popcount(MAX_PORTS'(push)));

  for (genvar gi = 0; gi < NR; gi++) begin : g_offset
    logic [NR-1:0] below;
    assign below      = push & ((NR'(1) << gi) - NR'(1));
    assign offset[gi] = OFF_W'(cfi_popcount(MAX_PORTS'(below)));
  end

endmodule

// File: rtl/cfi_log_queue.sv
// Multi-push, single-pop queue of CFI log records between the CFI filter and
// the CFI checker; raises a registered stall and a sticky overflow on drops.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  cfi_log_t                   log_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] cfi_i,
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
  output cfi_log_t                   log_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       stall_o,
  output logic                       overflow_o,
  input  logic                       clear_overflow_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = $clog2(NR_COMMIT_PORTS + 1);
  localparam int W     = CNT_W + 1;

  if (DEPTH < 2 * NR_COMMIT_PORTS || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("cfi_log_queue: DEPTH must be a power of two and >= 2*NR_COMMIT_PORTS");
  end

  logic [NR_COMMIT_PORTS-1:0]            push;
  logic [NR_COMMIT_PORTS-1:0][OFF_W-1:0] offset;
  logic [OFF_W-1:0]                      n_push;

  cfi_log_t                   mem [DEPTH];
  logic [PTR_W-1:0]           rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]           count_reg;
  logic                       overflow_reg;

  logic                       pop;
  logic [W-1:0]               free;
  logic [W-1:0]               n_acc;
  logic [NR_COMMIT_PORTS-1:0] accept;
  logic                       drop;

  cfi_log_compact #(
    .NR    (NR_COMMIT_PORTS),
    .OFF_W (OFF_W)
  ) u_compact (
    .cfi        (cfi_i),
    .commit_ack (commit_ack_i),
    .push       (push),
    .offset     (offset),
    .n_push     (n_push)
  );

  // A slot vacated by this cycle's pop is counted as free, so a full queue
  // being drained still accepts a push.
  always_comb begin
    pop    = (count_reg != '0) && ready_i;
    free   = W'(DEPTH) - W'(count_reg) + W'(pop);
    accept = '0;
    n_acc  = '0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (push[i] && (W'(offset[i]) < free)) begin
        accept[i] = 1'b1;
        n_acc     = n_acc + W'(1);
      end
    end
    drop = W'(n_push) > free;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
        if (accept[i]) begin
          mem[wr_ptr_reg + PTR_W'(offset[i])] <= log_i[i];
        end
      end
      wr_ptr_reg   <= wr_ptr_reg + PTR_W'(n_acc);
      rd_ptr_reg   <= rd_ptr_reg + PTR_W'(pop);
      count_reg    <= CNT_W'(W'(count_reg) + n_acc - W'(pop));
      overflow_reg <= drop | (overflow_reg & ~clear_overflow_i);
    end
  end

  assign log_o      = mem[rd_ptr_reg];
  assign valid_o    = (count_reg != '0);
  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;
  assign stall_o    = (W'(DEPTH) - W'(count_reg)) < W'(NR_COMMIT_PORTS);

endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed bench for cfi_log_queue: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  cfi_log_t   log_in [NR];
  logic [1:0] cfi   = '0;
  logic [1:0] ack   = '0;
  logic       ready = 1'b0;
  logic       clr   = 1'b0;
  cfi_log_t   log_out;
  logic       valid, stall, ovf;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  cfi_log_t mq[$];
  logic     m_ovf;

  cfi_log_queue #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .log_i            (log_in),
    .cfi_i            (cfi),
    .commit_ack_i     (ack),
    .log_o            (log_out),
    .valid_o          (valid),
    .ready_i          (ready),
    .stall_o          (stall),
    .overflow_o       (ovf),
    .clear_overflow_i (clr),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Reference model: a plain FIFO of records with a capacity of DEPTH.
  always @(posedge clk or negedge rst_n) begin : model
    cfi_log_t nq[$];
    int       room;
    int       taken;
    bit       lost;
    nq = mq;
    if (!rst_n) begin
      nq.delete();
      mq    <= nq;
      m_ovf <= 1'b0;
    end else begin
      room = DEPTH - nq.size();
      if (nq.size() != 0 && ready) begin
        void'(nq.pop_front());
        room = room + 1;
      end
      taken = 0;
      lost  = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (cfi[i] && ack[i]) begin
          if (taken < room) begin
            nq.push_back(log_in[i]);
            taken++;
          end else begin
            lost = 1'b1;
          end
        end
      end
      mq    <= nq;
      m_ovf <= lost ? 1'b1 : (clr ? 1'b0 : m_ovf);
    end
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("valid", 66'(valid), 66'(mq.size() != 0));
    chk("count", 66'(count), 66'(mq.size()));
    chk("stall", 66'(stall), 66'((DEPTH - mq.size()) < NR));
    chk("overflow", 66'(ovf), 66'(m_ovf));
    if (mq.size() != 0) chk("head", 66'(log_out), 66'(mq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  function automatic cfi_log_t mk(input logic [31:0] pc);
    cfi_log_t r;
    r.addr_pc = pc;
    r.target  = pc + 32'h40;
    r.kind    = pc[3:2];
    return r;
  endfunction

  task automatic drive(input logic [1:0] c, input logic [1:0] a,
                       input logic [31:0] pc0, input logic [31:0] pc1);
    cfi       = c;
    ack       = a;
    log_in[0] = mk(pc0);
    log_in[1] = mk(pc1);
  endtask

  task automatic idle();
    cfi = '0;
    ack = '0;
  endtask

  task automatic drain();
    idle();
    ready = 1'b1;
    for (int k = 0; k < 20 && mq.size() != 0; k++) tick();
    ready = 1'b0;
    chk("drain_empty", 66'(valid), 66'(0));
  endtask

  task automatic fill7(input logic [31:0] base);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b11, base + 32'(8 * k), base + 32'(8 * k + 4));
      tick();
    end
    drive(2'b01, 2'b01, base + 32'h30, 32'h0);
    tick();
    chk("fill_count7", 66'(count), 66'(7));
    chk("fill_stall", 66'(stall), 66'(1));
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] last_pc;
    bit          seen_stall;
    log_in[0] = '0;
    log_in[1] = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_count", 66'(count), 66'(0));
    chk("rst_valid", 66'(valid), 66'(0));
    chk("rst_log", 66'(log_out), 66'(0));
    chk("rst_stall", 66'(stall), 66'(0));
    chk("rst_ovf", 66'(ovf), 66'(0));
    rst_n = 1'b1;
    tick();

    // Single push, held without pop
    drive(2'b01, 2'b01, 32'h100, 32'h0);
    tick();
    idle();
    chk("t1_valid", 66'(valid), 66'(1));
    chk("t1_pc", 66'(log_out.addr_pc), 66'(32'h100));
    chk("t1_count", 66'(count), 66'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_hold", 66'(log_out.addr_pc), 66'(32'h100));
    end
    drain();

    // Gap compaction: only port 1 passes the filter
    drive(2'b10, 2'b11, 32'h200, 32'h204);
    tick();
    idle();
    chk("t2_count", 66'(count), 66'(1));
    chk("t2_pc", 66'(log_out.addr_pc), 66'(32'h204));
    drain();

    // Streaming with commit honouring stall
    ready      = 1'b1;
    pc         = 32'h1000;
    last_pc    = 32'h0;
    seen_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!stall) begin
        drive(2'b11, 2'b11, pc, pc + 32'h4);
        pc = pc + 32'h8;
      end else begin
        idle();
      end
      tick();
      if (stall && !seen_stall) begin
        seen_stall = 1'b1;
        chk("t3_stall_at7", 66'(count), 66'(7));
      end
      if (valid) begin
        chk("t3_order", 66'(log_out.addr_pc > last_pc), 66'(1));
        last_pc = log_out.addr_pc;
      end
    end
    chk("t3_seen_stall", 66'(seen_stall), 66'(1));
    chk("t3_no_ovf", 66'(ovf), 66'(0));
    drain();

    // Overflow: push 2 into 1 free slot without pop
    fill7(32'h2000);
    drive(2'b11, 2'b11, 32'h2100, 32'h2104);
    tick();
    chk("t4_count8", 66'(count), 66'(8));
    chk("t4_ovf", 66'(ovf), 66'(1));
    // Drop in the same cycle as a clear keeps overflow set
    drive(2'b01, 2'b01, 32'h2200, 32'h0);
    clr = 1'b1;
    tick();
    idle();
    chk("t6_drop_wins", 66'(ovf), 66'(1));
    tick();
    clr = 1'b0;
    chk("t6_cleared", 66'(ovf), 66'(0));
    drain();

    // Same-cycle pop frees a slot for the second push
    fill7(32'h3000);
    drive(2'b11, 2'b11, 32'h3100, 32'h3104);
    ready = 1'b1;
    tick();
    idle();
    ready = 1'b0;
    chk("t5_count8", 66'(count), 66'(8));
    chk("t5_no_ovf", 66'(ovf), 66'(0));
    drain();

    // Asynchronous reset mid-burst
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b11, 32'h4000 + 32'(8 * k), 32'h4004 + 32'(8 * k));
      tick();
    end
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_count", 66'(count), 66'(0));
    chk("arst_valid", 66'(valid), 66'(0));
    tick();
    rst_n = 1'b1;
    ready = 1'b0;
    tick();

    // Walk pointers to 7, then a two-record write that wraps
    ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(2'b01, 2'b01, 32'h700 + 32'(4 * k), 32'h0);
      tick();
    end
    idle();
    tick();
    ready = 1'b0;
    drive(2'b11, 2'b11, 32'h800, 32'h804);
    tick();
    idle();
    chk("t7_first", 66'(log_out.addr_pc), 66'(32'h800));
    chk("t7_count", 66'(count), 66'(2));
    ready = 1'b1;
    tick();
    chk("t7_second", 66'(log_out.addr_pc), 66'(32'h804));
    tick();
    chk("t7_empty", 66'(valid), 66'(0));
    ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
